// File: rtl/fft_r2_bfly_stage_if.sv
// Streaming bus of one radix-2 butterfly stage: input pair, twiddle ROM port and output pair.
interface fft_r2_bfly_stage_if #(
  parameter int DW    = 17,
  parameter int TW    = 10,
  parameter int LOG2N = 4,
  parameter int SCALE = 0
);
  localparam int OW = (SCALE != 0) ? DW : DW + 1;
  localparam int AW = LOG2N - 1;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a_re;
  logic signed [DW-1:0] a_im;
  logic signed [DW-1:0] b_re;
  logic signed [DW-1:0] b_im;
  logic [AW-1:0]        tw_addr;
  logic signed [TW-1:0] tw_re;
  logic signed [TW-1:0] tw_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] x_re;
  logic signed [OW-1:0] x_im;
  logic signed [OW-1:0] y_re;
  logic signed [OW-1:0] y_im;
  logic                 out_last;
  logic                 ovf;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    input  in_ready, tw_addr, out_valid, x_re, x_im, y_re, y_im, out_last, ovf
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, out_ready,
    output in_ready, tw_addr, out_valid, x_re, x_im, y_re, y_im, out_last, ovf
  );
endinterface

// File: rtl/fft_r2_bfly_stage.sv
// Radix-2 DIT butterfly stage: x=a+b*w, y=a-b*w, 3-stage valid/ready pipeline with
// optional 1/2 scaling, output saturation and frame-position tracking.
module fft_r2_bfly_stage #(
  parameter int DW    = 17,
  parameter int TW    = 10,
  parameter int LOG2N = 4,
  parameter int STAGE = 0,
  parameter int SCALE = 0
) (
  input logic               clk,
  input logic               rst,
  fft_r2_bfly_stage_if.slave bus
);
  localparam int OW  = (SCALE != 0) ? DW : DW + 1;
  localparam int AW  = LOG2N - 1;
  localparam int PW  = DW + TW;
  localparam int PW1 = PW + 1;
  localparam int RW  = DW + 2;
  localparam int SW  = DW + 3;
  localparam int SH  = AW - STAGE;

  localparam logic [AW-1:0]        LAST_IDX    = '1;
  localparam logic [AW-1:0]        STRIDE_MASK = AW'((1 << STAGE) - 1);
  localparam logic signed [PW1-1:0] RND        = PW1'(1 << (TW - 3));
  localparam logic signed [SW-1:0] SAT_MAX     = SW'((1 << (OW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN     = SW'(-(1 << (OW - 1)));

  logic en;
  logic accept;

  logic [AW-1:0] pair_cnt_q, pair_cnt_d;

  logic                 v1_q, v1_d, last1_q, last1_d;
  logic signed [DW-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
  logic signed [DW-1:0] b1_re_q, b1_re_d, b1_im_q, b1_im_d;
  logic signed [TW-1:0] w1_re_q, w1_re_d, w1_im_q, w1_im_d;

  logic                 v2_q, v2_d, last2_q, last2_d;
  logic signed [DW-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
  logic signed [PW-1:0] prr_q, prr_d, pii_q, pii_d, pri_q, pri_d, pir_q, pir_d;

  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d, ovf_q, ovf_d;
  logic signed [OW-1:0] x_re_q, x_re_d, x_im_q, x_im_d, y_re_q, y_re_d, y_im_q, y_im_d;

  logic signed [PW1-1:0] pw_re, pw_im;
  logic signed [RW-1:0]  p_re, p_im;
  logic signed [SW-1:0]  s_xr, s_xi, s_yr, s_yi;
  logic signed [OW-1:0]  q_xr, q_xi, q_yr, q_yi;
  logic                  o_xr, o_xi, o_yr, o_yi;

  function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] s);
    if (SCALE != 0) return (s + SW'(1)) >>> 1;
    return s;
  endfunction

  // Returns {saturated_flag, clipped_value}.
  function automatic logic [OW:0] sat(input logic signed [SW-1:0] s);
    if (s > SAT_MAX) return {1'b1, SAT_MAX[OW-1:0]};
    if (s < SAT_MIN) return {1'b1, SAT_MIN[OW-1:0]};
    return {1'b0, s[OW-1:0]};
  endfunction

  assign bus.tw_addr   = (pair_cnt_q & STRIDE_MASK) << SH;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.ovf       = ovf_q;
  assign bus.x_re      = x_re_q;
  assign bus.x_im      = x_im_q;
  assign bus.y_re      = y_re_q;
  assign bus.y_im      = y_im_q;

  // S3 datapath: complex product recombination, rounding to sample scale, add/sub, scale, clip.
  always_comb begin
    pw_re = PW1'(prr_q) - PW1'(pii_q);
    pw_im = PW1'(pri_q) + PW1'(pir_q);
    p_re  = RW'((pw_re + RND) >>> (TW - 2));
    p_im  = RW'((pw_im + RND) >>> (TW - 2));
    s_xr  = scl(SW'(a2_re_q) + SW'(p_re));
    s_xi  = scl(SW'(a2_im_q) + SW'(p_im));
    s_yr  = scl(SW'(a2_re_q) - SW'(p_re));
    s_yi  = scl(SW'(a2_im_q) - SW'(p_im));
    {o_xr, q_xr} = sat(s_xr);
    {o_xi, q_xi} = sat(s_xi);
    {o_yr, q_yr} = sat(s_yr);
    {o_yi, q_yi} = sat(s_yi);
  end

  always_comb begin
    en     = !(out_valid_q && !bus.out_ready);
    accept = bus.in_valid && en;

    pair_cnt_d  = pair_cnt_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    a1_re_d     = a1_re_q;
    a1_im_d     = a1_im_q;
    b1_re_d     = b1_re_q;
    b1_im_d     = b1_im_q;
    w1_re_d     = w1_re_q;
    w1_im_d     = w1_im_q;
    v2_d        = v2_q;
    last2_d     = last2_q;
    a2_re_d     = a2_re_q;
    a2_im_d     = a2_im_q;
    prr_d       = prr_q;
    pii_d       = pii_q;
    pri_d       = pri_q;
    pir_d       = pir_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    y_re_d      = y_re_q;
    y_im_d      = y_im_q;

    if (accept) pair_cnt_d = pair_cnt_q + 1'b1;

    // The whole pipeline advances as one; a stalled output freezes every stage.
    if (en) begin
      v1_d        = bus.in_valid;
      last1_d     = bus.in_valid && (pair_cnt_q == LAST_IDX);
      a1_re_d     = bus.a_re;
      a1_im_d     = bus.a_im;
      b1_re_d     = bus.b_re;
      b1_im_d     = bus.b_im;
      w1_re_d     = bus.tw_re;
      w1_im_d     = bus.tw_im;

      v2_d        = v1_q;
      last2_d     = last1_q;
      a2_re_d     = a1_re_q;
      a2_im_d     = a1_im_q;
      prr_d       = PW'(b1_re_q) * PW'(w1_re_q);
      pii_d       = PW'(b1_im_q) * PW'(w1_im_q);
      pri_d       = PW'(b1_re_q) * PW'(w1_im_q);
      pir_d       = PW'(b1_im_q) * PW'(w1_re_q);

      out_valid_d = v2_q;
      out_last_d  = last2_q;
      ovf_d       = o_xr | o_xi | o_yr | o_yi;
      x_re_d      = q_xr;
      x_im_d      = q_xi;
      y_re_d      = q_yr;
      y_im_d      = q_yi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt_q  <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      a1_re_q     <= '0;
      a1_im_q     <= '0;
      b1_re_q     <= '0;
      b1_im_q     <= '0;
      w1_re_q     <= '0;
      w1_im_q     <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      a2_re_q     <= '0;
      a2_im_q     <= '0;
      prr_q       <= '0;
      pii_q       <= '0;
      pri_q       <= '0;
      pir_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      x_re_q      <= '0;
      x_im_q      <= '0;
      y_re_q      <= '0;
      y_im_q      <= '0;
    end else begin
      pair_cnt_q  <= pair_cnt_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      a1_re_q     <= a1_re_d;
      a1_im_q     <= a1_im_d;
      b1_re_q     <= b1_re_d;
      b1_im_q     <= b1_im_d;
      w1_re_q     <= w1_re_d;
      w1_im_q     <= w1_im_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      a2_re_q     <= a2_re_d;
      a2_im_q     <= a2_im_d;
      prr_q       <= prr_d;
      pii_q       <= pii_d;
      pri_q       <= pri_d;
      pir_q       <= pir_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
      y_re_q      <= y_re_d;
      y_im_q      <= y_im_d;
    end
  end
endmodule

// File: tb/tb_fft_r2_bfly_stage.sv
// Scoreboard bench: four stage variants (scale/stride) share one stimulus stream and are
// checked against a behavioural butterfly model and a valid-pipeline model.
module tb_fft_r2_bfly_stage;
  localparam int DW    = 17;
  localparam int TW    = 10;
  localparam int LOG2N = 4;
  localparam int NP    = 8;
  localparam int ND    = 4;
  localparam logic [3:0] SCV = 4'b0010;
  localparam logic [7:0] STV = 8'b00_01_11_11;
  localparam int ROMR [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
  localparam int ROMI [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  logic signed [19:0] xr [ND], xi [ND], yr [ND], yi [ND];
  logic ovv [ND], lastv [ND], ovld [ND], irdy [ND];
  logic [2:0] addr [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int SC = int'(SCV[g]);
    localparam int ST = int'(STV[2*g +: 2]);
    fft_r2_bfly_stage_if #(.DW(DW), .TW(TW), .LOG2N(LOG2N), .SCALE(SC)) bus ();
    fft_r2_bfly_stage #(.DW(DW), .TW(TW), .LOG2N(LOG2N), .STAGE(ST), .SCALE(SC)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
    );
    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;
    assign bus.a_re      = a_re;
    assign bus.a_im      = a_im;
    assign bus.b_re      = b_re;
    assign bus.b_im      = b_im;
    assign bus.tw_re     = TW'(ROMR[bus.tw_addr]);
    assign bus.tw_im     = TW'(ROMI[bus.tw_addr]);
    assign xr[g]    = 20'(bus.x_re);
    assign xi[g]    = 20'(bus.x_im);
    assign yr[g]    = 20'(bus.y_re);
    assign yi[g]    = 20'(bus.y_im);
    assign ovv[g]   = bus.ovf;
    assign lastv[g] = bus.out_last;
    assign ovld[g]  = bus.out_valid;
    assign irdy[g]  = bus.in_ready;
    assign addr[g]  = bus.tw_addr;
  end

  typedef struct {
    int xr [ND];
    int xi [ND];
    int yr [ND];
    int yi [ND];
    bit ov [ND];
    bit last;
  } exp_t;

  exp_t sbq [$];
  int   pc;
  bit   vp [3];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int st_of(input int i);
    return int'(STV[2*i +: 2]);
  endfunction

  function automatic bit sc_of(input int i);
    return SCV[i];
  endfunction

  function automatic int exp_addr(input int p, input int st);
    return (p & ((1 << st) - 1)) << (LOG2N - 1 - st);
  endfunction

  function automatic int rs();
    return int'($urandom_range(131071)) - 65536;
  endfunction

  function automatic void bfly(input longint ar, input longint ai, input longint br,
                               input longint bi, input longint wr, input longint wi,
                               input bit sc, output int o [4], output bit ov);
    longint pr, pim, mx, mn;
    longint s [4];
    logic signed [DW+1:0] t;
    int ow;
    ow  = sc ? DW : DW + 1;
    mx  = (64'sd1 <<< (ow - 1)) - 1;
    mn  = -mx - 1;
    pr  = (br * wr - bi * wi + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
    pim = (br * wi + bi * wr + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
    t = pr[DW+1:0];  pr  = t;
    t = pim[DW+1:0]; pim = t;
    s[0] = ar + pr; s[1] = ai + pim; s[2] = ar - pr; s[3] = ai - pim;
    ov = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > mx) begin s[k] = mx; ov = 1'b1; end
      else if (s[k] < mn) begin s[k] = mn; ov = 1'b1; end
      o[k] = int'(s[k]);
    end
  endfunction

  task automatic cycle(input bit v, input int ar, input int ai, input int br, input int bi,
                       input bit ordy);
    bit   en;
    exp_t e, o;
    int   r [4];
    bit   ov;
    int   k;
    @(negedge clk);
    in_valid  = v;
    a_re      = DW'(ar);
    a_im      = DW'(ai);
    b_re      = DW'(br);
    b_im      = DW'(bi);
    out_ready = ordy;
    #1;
    en = !(vp[2] && !ordy);
    for (int i = 0; i < ND; i++) begin
      check($sformatf("in_ready[%0d]", i), int'(irdy[i]), int'(en));
      check($sformatf("out_valid[%0d]", i), int'(ovld[i]), int'(vp[2]));
      if (v) check($sformatf("tw_addr[%0d]", i), int'(addr[i]), exp_addr(pc, st_of(i)));
    end
    if (vp[2] && ordy) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: output beat with no expected entry");
      end else begin
        o = sbq.pop_front();
        for (int i = 0; i < ND; i++) begin
          check($sformatf("x_re[%0d]", i), int'(xr[i]), o.xr[i]);
          check($sformatf("x_im[%0d]", i), int'(xi[i]), o.xi[i]);
          check($sformatf("y_re[%0d]", i), int'(yr[i]), o.yr[i]);
          check($sformatf("y_im[%0d]", i), int'(yi[i]), o.yi[i]);
          check($sformatf("ovf[%0d]", i), int'(ovv[i]), int'(o.ov[i]));
          check($sformatf("out_last[%0d]", i), int'(lastv[i]), int'(o.last));
        end
      end
    end
    if (v && en) begin
      for (int i = 0; i < ND; i++) begin
        k = exp_addr(pc, st_of(i));
        bfly(ar, ai, br, bi, ROMR[k], ROMI[k], sc_of(i), r, ov);
        e.xr[i] = r[0]; e.xi[i] = r[1]; e.yr[i] = r[2]; e.yi[i] = r[3]; e.ov[i] = ov;
      end
      e.last = (pc == NP - 1);
      sbq.push_back(e);
      pc = (pc + 1) % NP;
    end
    if (en) begin
      vp[2] = vp[1];
      vp[1] = vp[0];
      vp[0] = v;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), int'(ovld[i]), 0);
      check($sformatf("rst_x_re[%0d]", i), int'(xr[i]), 0);
      check($sformatf("rst_x_im[%0d]", i), int'(xi[i]), 0);
      check($sformatf("rst_y_re[%0d]", i), int'(yr[i]), 0);
      check($sformatf("rst_y_im[%0d]", i), int'(yi[i]), 0);
      check($sformatf("rst_ovf[%0d]", i), int'(ovv[i]), 0);
      check($sformatf("rst_last[%0d]", i), int'(lastv[i]), 0);
    end
    sbq.delete();
    vp = '{default: 1'b0};
    pc = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && sbq.size() > 0; k++) cycle(1'b0, 0, 0, 0, 0, 1'b1);
    check("drain_left", sbq.size(), 0);
  endtask

  initial begin
    int burst;
    int run;
    bit ordy;
    bit v;
    burst = 0;
    pulse_rst();

    // Directed frame: pair 0 sees w=1, pair 2 w=(181,-181), pair 4 w=-j on the stride-1 stage.
    cycle(1'b1, 100, 50, 30, -20, 1'b1);
    cycle(1'b1, -200, 300, 1234, -4321, 1'b1);
    cycle(1'b1, 65535, 0, 65535, 65535, 1'b1);
    cycle(1'b1, 1000, 0, 1000, 1000, 1'b1);
    cycle(1'b1, 100, 50, 30, -20, 1'b1);
    cycle(1'b0, 0, 0, 0, 0, 1'b1);
    for (int n = 5; n < 16; n++) cycle(1'b1, rs(), rs(), rs(), rs(), 1'b1);
    drain();

    // Random stream with random back-pressure and 5-cycle stall bursts.
    for (int c = 0; c < 240; c++) begin
      if (burst == 0 && (c == 50 || $urandom_range(19) == 0)) burst = 5;
      if (burst > 0) begin
        ordy = 1'b0;
        burst--;
      end else begin
        ordy = ($urandom_range(3) != 0);
      end
      v = ($urandom_range(4) != 0);
      cycle(v, rs(), rs(), rs(), rs(), ordy);
    end
    drain();

    // Reset with a full pipeline after pair 5 of a frame.
    run = 0;
    while (!(pc == 5 && run >= 3) && run < 40) begin
      cycle(1'b1, rs(), rs(), rs(), rs(), 1'b1);
      run++;
    end
    pulse_rst();
    for (int n = 0; n < 10; n++) cycle(1'b1, rs(), rs(), rs(), rs(), 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
